// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing single-port DataMem between core and host, with bounded lock.
// Optional DMEM_ARB_STALLCNT_EN adds the c_stall_cnt core stall counter output.
module dmem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          c_req,
  input  logic          c_lock,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_lock,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STALLCNT_EN
  ,
  output logic [15:0]   c_stall_cnt
`endif
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  typedef enum logic {SIDE_CORE = 1'b0, SIDE_HOST = 1'b1} side_e;

  side_e          last_q, last_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           c_rvalid_q, c_rvalid_d;
  logic           h_rvalid_q, h_rvalid_d;
  logic [DW-1:0]  c_rdata_q, c_rdata_d;
  logic [DW-1:0]  h_rdata_q, h_rdata_d;
  logic           gnt_core, gnt_host, other_req;

  // Grant decision: a locked last grantee keeps the port until hold_q reaches MAX_HOLD
  always_comb begin
    gnt_core = 1'b0;
    gnt_host = 1'b0;
    if (Reset) begin
      gnt_core = 1'b0;
      gnt_host = 1'b0;
    end else if (c_req && h_req) begin
      if (last_q == SIDE_CORE) begin
        if (c_lock && (hold_q < HOLD_MAX)) gnt_core = 1'b1;
        else                               gnt_host = 1'b1;
      end else begin
        if (h_lock && (hold_q < HOLD_MAX)) gnt_host = 1'b1;
        else                               gnt_core = 1'b1;
      end
    end else if (c_req) begin
      gnt_core = 1'b1;
    end else if (h_req) begin
      gnt_host = 1'b1;
    end else begin
      gnt_core = 1'b0;
      gnt_host = 1'b0;
    end
  end

  // Memory port mux: idle port drives zeros
  always_comb begin
    mem_addr  = {AW{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DW{1'b0}};
    if (gnt_core) begin
      mem_addr  = c_addr;
      mem_we    = c_we;
      mem_wdata = c_wdata;
    end else if (gnt_host) begin
      mem_addr  = h_addr;
      mem_we    = h_we;
      mem_wdata = h_wdata;
    end else begin
      mem_addr  = {AW{1'b0}};
    end
  end

  // Next arbitration state and read-return capture
  always_comb begin
    last_d     = last_q;
    hold_d     = hold_q;
    other_req  = 1'b0;
    c_rvalid_d = gnt_core && !c_we;
    h_rvalid_d = gnt_host && !h_we;
    c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
    h_rdata_d  = h_rvalid_d ? mem_rdata : h_rdata_q;
    if (gnt_core || gnt_host) begin
      last_d    = gnt_core ? SIDE_CORE : SIDE_HOST;
      other_req = gnt_core ? h_req : c_req;
      // hold counts only consecutive grants taken while the other side is waiting
      if (!other_req)                hold_d = {HCW{1'b0}};
      else if (last_d != last_q)     hold_d = HCW'(1);
      else if (hold_q == HOLD_MAX)   hold_d = hold_q;
      else                           hold_d = hold_q + HCW'(1);
    end else begin
      hold_d = {HCW{1'b0}};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q     <= SIDE_HOST;
      hold_q     <= {HCW{1'b0}};
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= {DW{1'b0}};
      h_rdata_q  <= {DW{1'b0}};
    end else begin
      last_q     <= last_d;
      hold_q     <= hold_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      h_rdata_q  <= h_rdata_d;
    end
  end

  assign c_gnt    = gnt_core;
  assign h_gnt    = gnt_host;
  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign h_rdata  = h_rdata_q;

`ifdef DMEM_ARB_STALLCNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles the core waited without a grant
  always_comb begin
    stall_d = stall_q;
    if (c_req && !gnt_core && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    else                                             stall_d = stall_q;
  end

  // Stall counter register
  always_ff @(posedge Clk) begin
    if (Reset) stall_q <= 16'd0;
    else       stall_q <= stall_d;
  end

  assign c_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios then constrained-random
// traffic checked against a behavioural arbitration/memory model.
module tb_dmem_port_arbiter;
  localparam int MAX_HOLD = 4;

  logic       Clk;
  logic       Reset;
  logic       c_req, c_lock, c_we, h_req, h_lock, h_we;
  logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
  logic       c_gnt, c_rvalid, h_gnt, h_rvalid, mem_we;
  logic [7:0] c_rdata, h_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STALLCNT_EN
  logic [15:0] c_stall_cnt;
`endif

  dmem_port_arbiter #(.AW(8), .DW(8), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk(Clk), .Reset(Reset),
    .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STALLCNT_EN
    , .c_stall_cnt(c_stall_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DataMem stand-in driven by the DUT's memory port
  logic [7:0] dmem [0:255];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge Clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  // Reference model state
  logic [7:0]  ref_mem [0:255];
  bit          m_last_core;
  int          m_run;
  bit          e_c_rvalid, e_h_rvalid;
  logic [7:0]  e_c_rdata, e_h_rdata;
  logic [15:0] e_stall;
  bit          c_pend, h_pend;
  int          total, bad;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_c(input bit r, input bit l, input bit w, input logic [7:0] a, input logic [7:0] d);
    c_req = r; c_lock = l; c_we = w; c_addr = a; c_wdata = d;
  endtask

  task automatic drive_h(input bit r, input bit l, input bit w, input logic [7:0] a, input logic [7:0] d);
    h_req = r; h_lock = l; h_we = w; h_addr = a; h_wdata = d;
  endtask

  // One clock cycle: check combinational and registered outputs, then advance the model
  task automatic step(input bit rst);
    bit eg_c, eg_h, keep, other;
    logic [7:0] ea, ed;
    bit ew;
    Reset = rst;
    @(negedge Clk);
    eg_c = 1'b0; eg_h = 1'b0;
    if (!rst) begin
      if (c_req && h_req) begin
        keep = (m_last_core ? c_lock : h_lock) && (m_run < MAX_HOLD);
        eg_c = keep ? m_last_core : !m_last_core;
        eg_h = !eg_c;
      end else begin
        eg_c = c_req;
        eg_h = h_req && !c_req;
      end
    end
    ea = 8'h00; ed = 8'h00; ew = 1'b0;
    if (eg_c) begin ea = c_addr; ed = c_wdata; ew = c_we; end
    if (eg_h) begin ea = h_addr; ed = h_wdata; ew = h_we; end
    chk("c_gnt", {15'd0, c_gnt}, {15'd0, eg_c});
    chk("h_gnt", {15'd0, h_gnt}, {15'd0, eg_h});
    chk("mem_we", {15'd0, mem_we}, {15'd0, ew});
    chk("mem_addr", {8'd0, mem_addr}, {8'd0, ea});
    chk("mem_wdata", {8'd0, mem_wdata}, {8'd0, ed});
    chk("c_rvalid", {15'd0, c_rvalid}, {15'd0, e_c_rvalid});
    chk("h_rvalid", {15'd0, h_rvalid}, {15'd0, e_h_rvalid});
    chk("c_rdata", {8'd0, c_rdata}, {8'd0, e_c_rdata});
    chk("h_rdata", {8'd0, h_rdata}, {8'd0, e_h_rdata});
`ifdef DMEM_ARB_STALLCNT_EN
    chk("c_stall_cnt", c_stall_cnt, e_stall);
`endif
    if (rst) begin
      m_last_core = 1'b0; m_run = 0;
      e_c_rvalid = 1'b0; e_h_rvalid = 1'b0;
      e_c_rdata = 8'h00; e_h_rdata = 8'h00;
      e_stall = 16'd0; c_pend = 1'b0; h_pend = 1'b0;
    end else begin
      if (c_req && !eg_c && e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
      e_c_rvalid = eg_c && !c_we;
      e_h_rvalid = eg_h && !h_we;
      if (e_c_rvalid) e_c_rdata = ref_mem[c_addr];
      if (e_h_rvalid) e_h_rdata = ref_mem[h_addr];
      if (eg_c && c_we) ref_mem[c_addr] = c_wdata;
      if (eg_h && h_we) ref_mem[h_addr] = h_wdata;
      if (eg_c || eg_h) begin
        other = eg_c ? h_req : c_req;
        if (!other)                m_run = 0;
        else if (eg_c == m_last_core) m_run = (m_run + 1 > MAX_HOLD) ? MAX_HOLD : m_run + 1;
        else                       m_run = 1;
        m_last_core = eg_c;
      end else begin
        m_run = 0;
      end
      c_pend = c_req && !eg_c;
      h_pend = h_req && !eg_h;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin dmem[i] = 8'h00; ref_mem[i] = 8'h00; end
    drive_c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_h(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    // Reset state
    step(1'b1);

    // Host preload with core idle
    for (int i = 0; i < 4; i++) begin
      drive_h(1'b1, 1'b0, 1'b1, 8'(i), 8'(8'h11 + i));
      step(1'b0);
    end
    drive_h(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0);
    for (int i = 0; i < 4; i++) chk("preload_mem", {8'd0, dmem[i]}, 16'(8'h11 + i));

    // Both reading, no lock: strict alternation starting with core after reset
    step(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_c(1'b1, 1'b0, 1'b0, 8'(i), 8'h00);
      drive_h(1'b1, 1'b0, 1'b0, 8'(3 - i), 8'h00);
      step(1'b0);
    end

    // Core lock holds MAX_HOLD cycles against a waiting host
    step(1'b1);
    drive_c(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
    drive_h(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    repeat (MAX_HOLD + 2) step(1'b0);

    // Core write then read of the same address
    drive_h(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_c(1'b1, 1'b0, 1'b1, 8'h20, 8'hA5);
    step(1'b0);
    drive_c(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    step(1'b0);
    drive_c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0);

    // Reset right after a granted read
    drive_c(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    step(1'b0);
    step(1'b1);
    drive_h(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
    step(1'b0);
    drive_c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_h(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0);

    // Host locked against a waiting core
    step(1'b1);
    drive_h(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
    step(1'b0);
    drive_c(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
    repeat (3) step(1'b0);
`ifdef DMEM_ARB_STALLCNT_EN
    chk("stall_after_lock", c_stall_cnt, 16'd3);
`endif
    drive_h(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0);
    drive_c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0);

    // Random traffic obeying the hold-stable rule, small address window for RAW hits
    for (int n = 0; n < 500; n++) begin
      if (c_pend && $urandom_range(7) != 0) c_lock = 1'($urandom_range(1));
      else if (c_pend) c_req = 1'b0;
      else drive_c(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   8'($urandom_range(7)), 8'($urandom));
      if (h_pend && $urandom_range(7) != 0) h_lock = 1'($urandom_range(1));
      else if (h_pend) h_req = 1'b0;
      else drive_h(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   8'($urandom_range(7)), 8'($urandom));
      step($urandom_range(99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
